// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider.
// Latency: WIDTH+1 edges from accept for iterative ops, 1 edge for special-case divides and FAST_MUL multiplies.
// Backpressure: one op in flight; result held in DONE until out_ready, in_ready only in IDLE.
module alu_muldiv #(
    parameter int WIDTH    = 32,
    parameter int FAST_MUL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             kill,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       func3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [2:0]       op;
    logic             neg;
    logic [CW-1:0]    cnt;
    // m: multiplicand (mul) or divisor (div); hi/lo: product halves or remainder/quotient
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    logic accept;
    assign accept = in_valid && in_ready && !kill;

    // ---------------- accept-side decode ----------------
    logic             is_mul_in, a_sgn, b_sgn, sa, sb, neg_in;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             div_zero, ovf, special, fast;
    logic [WIDTH-1:0] special_res;

    assign is_mul_in = ~func3[2];
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    assign a_sgn = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
    assign b_sgn = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    assign sa    = a_sgn & rs1[WIDTH-1];
    assign sb    = b_sgn & rs2[WIDTH-1];
    assign a_abs = sa ? -rs1 : rs1;
    assign b_abs = sb ? -rs2 : rs2;
    // remainder follows the dividend sign; products and quotients take the XOR
    assign neg_in = (func3[2] && func3[1]) ? sa : (sa ^ sb);

    assign div_zero = func3[2] && (rs2 == '0);
    assign ovf      = func3[2] && !func3[0] && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == {WIDTH{1'b1}});
    assign special  = div_zero || ovf;
    assign special_res = div_zero ? (func3[1] ? rs1 : {WIDTH{1'b1}})
                                  : (func3[1] ? {WIDTH{1'b0}} : rs1);

    logic [2*WIDTH-1:0] fast_prod, fast_sgn;
    logic [WIDTH-1:0]   fast_res;
    assign fast      = (FAST_MUL != 0) && is_mul_in;
    assign fast_prod = {{WIDTH{1'b0}}, a_abs} * {{WIDTH{1'b0}}, b_abs};
    assign fast_sgn  = neg_in ? -fast_prod : fast_prod;
    assign fast_res  = (func3[1:0] == 2'b00) ? fast_sgn[WIDTH-1:0] : fast_sgn[2*WIDTH-1:WIDTH];

    // ---------------- one iteration step ----------------
    logic [WIDTH:0]   msum;
    logic [WIDTH:0]   rsh, dsub;
    logic             take;
    logic [WIDTH-1:0] nhi, nlo;

    // shift-add: add multiplicand into the upper half when the current multiplier bit is set
    assign msum = {1'b0, hi} + (lo[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    // restoring: shift in the next dividend bit and subtract if it fits
    assign rsh  = {hi, lo[WIDTH-1]};
    assign dsub = rsh - {1'b0, m};
    assign take = ~dsub[WIDTH];
    assign nhi  = op[2] ? (take ? dsub[WIDTH-1:0] : rsh[WIDTH-1:0]) : msum[WIDTH:1];
    assign nlo  = op[2] ? {lo[WIDTH-2:0], take} : {msum[0], lo[WIDTH-1:1]};

    // ---------------- final sign fix / select ----------------
    logic [2*WIDTH-1:0] full, full_sgn;
    logic [WIDTH-1:0]   dv, fin_res;
    assign full     = {nhi, nlo};
    assign full_sgn = neg ? -full : full;
    assign dv       = op[1] ? nhi : nlo;
    assign fin_res  = op[2] ? (neg ? -dv : dv)
                            : ((op[1:0] == 2'b00) ? full_sgn[WIDTH-1:0] : full_sgn[2*WIDTH-1:WIDTH]);

    // Control FSM and datapath registers; kill overrides every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op     <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            m      <= '0;
            hi     <= '0;
            lo     <= '0;
            result <= '0;
        end else if (kill) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op  <= func3;
                        neg <= neg_in;
                        cnt <= CW'(WIDTH - 1);
                        hi  <= '0;
                        m   <= is_mul_in ? a_abs : b_abs;
                        lo  <= is_mul_in ? b_abs : a_abs;
                        if (special) begin
                            result <= special_res;
                            state  <= S_DONE;
                        end else if (fast) begin
                            result <= fast_res;
                            state  <= S_DONE;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    hi  <= nhi;
                    lo  <= nlo;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result <= fin_res;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative multiply/divide unit for the RV32M extension, sitting beside the single-cycle integer ALU in the execute stage of the unicycle core. It accepts one operation at a time through a valid/ready handshake, runs a shift-add multiplier or a restoring divider for a parametrised number of cycles, and holds the result until the consumer takes it. The core stalls on `in_ready`/`out_valid`, and a synchronous `kill` discards in-flight work on pipeline flush.

## Interface
- `WIDTH`, 32: operand and result width. Must be ≥ 4.
- `FAST_MUL`, 0: 1 = every multiply completes in 1 cycle using a combinational product. 0 = multiplies are iterative.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset. Asynchronous, active-low.
- `kill` input 1: synchronous abort of the current operation.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept. Equals (state == IDLE).
- `func3` input 3: operation select.
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1` input WIDTH: multiplicand / dividend.
- `rs2` input WIDTH: multiplier / divisor.
- `out_valid` output 1: `result` valid. Equals (state == DONE).
- `out_ready` input 1: consumer accepts the result.
- `result` output WIDTH: registered result.
- `busy` output 1: state != IDLE.

## Operation
- States:
  - IDLE: in_ready = 1.
  - CALC: iterating.
  - DONE: out_valid = 1.
- Accept when `in_valid && in_ready && !kill`. On accept, latch `func3`, operand magnitudes and the result sign.
- Signed handling: each operand is taken as signed for its op and replaced by its absolute value.
  - Signed operands: MULH both, MULHSU rs1 only, DIV/REM both.
  - Product sign = XOR of the signed operands' sign bits.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
  - Magnitudes are computed unsigned and negated (two's complement) in the final cycle when the sign is set.
- Multiply: form the 2·WIDTH-bit product.
  - MUL returns the low WIDTH bits.
  - MULH, MULHSU and MULHU return the high WIDTH bits.
- Divide: restoring divider, one quotient bit per cycle, MSB first. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases bypass CALC iteration. The result is loaded directly and the op takes the 1-cycle path.
  - Divide by zero: DIV and DIVU return all-ones. REM and REMU return `rs1` unchanged.
  - Signed overflow (rs1 = 1 followed by WIDTH-1 zeros, rs2 = all-ones) on DIV: returns rs1.
  - Signed overflow on REM: returns 0.
- Iteration counter: $clog2(WIDTH)+1 bits. Loaded with WIDTH-1 on accept and decremented each CALC cycle. CALC exits after the cycle in which the counter is 0.
- DONE → IDLE on `out_ready`. While in DONE, `result` is held stable until the handshake.
- `kill` takes priority over everything:
  - Next state is IDLE and `out_valid` drops on the next edge.
  - No result is delivered.
  - An `in_valid` in the same cycle is not accepted.
  - `kill` in IDLE has no effect.

## Timing
- Reset (`rst_n` low, asynchronous):
  - state = IDLE, `result` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1.
  - Counter and operand registers are cleared to 0.
- Reset mid-operation aborts immediately. No result is produced after release.
- Latency, measured from the accepting edge to the first cycle with `out_valid` high:
  - Iterative ops: WIDTH+1 edges. This is WIDTH CALC cycles plus the sign-fix/writeback edge into DONE.
  - Special-case divides, and multiplies with FAST_MUL = 1: 1 edge, going directly IDLE → DONE.
- Throughput: one op per (latency + 1) cycles at minimum. `in_ready` rises on the edge that completes the output handshake, never in the same cycle as `out_valid`.
- Inputs `rs1`, `rs2` and `func3` are sampled only on the accepting edge. Later changes have no effect.
- No combinational path from `in_valid` to `out_valid`, or from `out_ready` to `in_ready`.

## Test plan
- **MUL**, WIDTH = 32, FAST_MUL = 0: rs1 = 0xFFFFFFFD, rs2 = 7.
  - `result` = 0xFFFFFFEB.
  - `out_valid` is first high 33 edges after accept.
  - `in_ready` is 0 throughout.
- **High multiplies**:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - Repeat all three with FAST_MUL = 1: identical results, latency 1.
- **Divide**:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD.
  - REM 0xFFFFFFF9 / 2 → 0xFFFFFFFF.
  - DIVU 100 / 7 → 0x0000000E.
  - REMU 100 / 7 → 0x00000002.
  - Each takes 33 edges.
- **Special cases**, latency 1:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 0x00000005.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM 0x80000000 / 0xFFFFFFFF → 0x00000000.
- **Backpressure**: hold `out_ready` = 0 for 5 cycles after `out_valid` rises.
  - `result` and `out_valid` stay stable and `in_ready` stays 0.
  - Raise `out_ready` for one cycle: `in_ready` = 1 on the next cycle.
  - A new op issued then is accepted.
- **Kill and reset**:
  - Assert `kill` on the 10th CALC cycle of a DIV: `out_valid` never rises and `in_ready` = 1 next cycle.
  - `kill` together with `in_valid` in IDLE: the request is not accepted.
  - Pulse `rst_n` low mid-CALC: outputs are at reset values immediately.
